// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } i2c_tgt_state_t;

    localparam int unsigned I2C_BITS       = 8;
    localparam int unsigned I2C_ACK_BIT    = 8;
    localparam logic [6:0]  I2C_GCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_line_sync.sv
// 2-FF synchronizer for SCL/SDA plus SCL edge and START/STOP decode.
// Events are combinational from the synchronized level and its previous value.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_sync_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;
    logic       sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign sda_sync_o = sda_s;
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target endpoint: decodes address, pointer and data bytes into single-cycle register strobes.
// Define I2C_TARGET_GCALL_EN to ACK the general-call address and write from pointer 8'h00.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned MIN_LOW_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       stop_det,
    output logic [3:0] state_dbg_o
);

    localparam logic [3:0] LAST_BIT = 4'(I2C_BITS - 1);
    localparam logic [3:0] ACK_IDX  = 4'(I2C_ACK_BIT);

    if (MIN_LOW_CYC == 0) begin : g_cfg_check
        $error("MIN_LOW_CYC must be at least 1");
    end

    logic sda_s, scl_rise, scl_fall, start_ev, stop_ev, gcall_hit, byte_done;

    i2c_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_sync_o (sda_s),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_ev),
        .stop_det   (stop_ev)
    );

    i2c_tgt_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       rise_seen_q, rise_seen_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, addr_q, addr_d, wdata_q, wdata_d;
    logic       rw_q, rw_d, gcall_q, gcall_d, sda_q, sda_d;
    logic       we_q, we_d, re_q, re_d, rd_pend_q, rd_pend_d;
    logic       busy_q, busy_d, stop_q, stop_d;

`ifdef I2C_TARGET_GCALL_EN
    assign gcall_hit = (rx_q == {I2C_GCALL_ADDR, 1'b0});
`else
    assign gcall_hit = 1'b0;
`endif

    assign byte_done = (bit_cnt_q == LAST_BIT);

    // Bank strobes: reg_we/reg_re are high for exactly one clk with reg_addr (and
    // reg_wdata) stable in that cycle; reg_rdata is captured on the following clk.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rise_seen_d = rise_seen_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        gcall_d     = gcall_q;
        sda_d       = sda_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        rd_pend_d   = re_q;
        busy_d      = busy_q;
        stop_d      = stop_ev;

        if (we_q) addr_d = addr_q + 8'd1;
        if (rd_pend_q) tx_d = reg_rdata;

        if (stop_ev) begin
            state_d     = ST_IDLE;
            sda_d       = 1'b1;
            busy_d      = 1'b0;
            bit_cnt_d   = '0;
            rise_seen_d = 1'b0;
        end else if (start_ev) begin
            state_d     = ST_ADDR;
            sda_d       = 1'b1;
            bit_cnt_d   = '0;
            rise_seen_d = 1'b0;
        end else if (scl_rise && state_q != ST_IDLE && state_q != ST_IGNORE) begin
            rx_d        = {rx_q[6:0], sda_s};
            rise_seen_d = 1'b1;
            if (state_q == ST_RDATA_ACK && !sda_s) begin
                addr_d = addr_q + 8'd1;
                re_d   = 1'b1;
            end
        end else if (scl_fall && rise_seen_q) begin
            // The falling edge right after START has no preceding rise and is skipped.
            rise_seen_d = 1'b0;
            bit_cnt_d   = byte_done ? ACK_IDX : bit_cnt_q + 4'd1;
            case (state_q)
                ST_ADDR: if (byte_done) begin
                    if (rx_q[7:1] == DEV_ADDR) begin
                        state_d = ST_ADDR_ACK;
                        sda_d   = 1'b0;
                        rw_d    = rx_q[0];
                        gcall_d = 1'b0;
                        busy_d  = 1'b1;
                        re_d    = rx_q[0];
                    end else if (gcall_hit) begin
                        state_d = ST_ADDR_ACK;
                        sda_d   = 1'b0;
                        rw_d    = 1'b0;
                        gcall_d = 1'b1;
                        busy_d  = 1'b1;
                        addr_d  = 8'h00;
                    end else begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                    end
                end
                ST_ADDR_ACK: begin
                    bit_cnt_d = '0;
                    sda_d     = rw_q ? tx_q[7] : 1'b1;
                    state_d   = rw_q ? ST_RDATA : (gcall_q ? ST_WDATA : ST_PTR);
                end
                ST_PTR: if (byte_done) begin
                    addr_d  = rx_q;
                    sda_d   = 1'b0;
                    state_d = ST_PTR_ACK;
                end
                ST_WDATA: if (byte_done) begin
                    wdata_d = rx_q;
                    we_d    = 1'b1;
                    sda_d   = 1'b0;
                    state_d = ST_WDATA_ACK;
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    bit_cnt_d = '0;
                    sda_d     = 1'b1;
                    state_d   = ST_WDATA;
                end
                ST_RDATA: if (byte_done) begin
                    sda_d   = 1'b1;
                    state_d = ST_RDATA_ACK;
                end else begin
                    sda_d = tx_q[6];
                    tx_d  = {tx_q[6:0], 1'b0};
                end
                ST_RDATA_ACK: begin
                    bit_cnt_d = '0;
                    if (!rx_q[0]) begin
                        sda_d   = tx_q[7];
                        state_d = ST_RDATA;
                    end else begin
                        sda_d   = 1'b1;
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rise_seen_q <= 1'b0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            gcall_q     <= 1'b0;
            sda_q       <= 1'b1;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rise_seen_q <= rise_seen_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            gcall_q     <= gcall_d;
            sda_q       <= sda_d;
            we_q        <= we_d;
            re_q        <= re_d;
            rd_pend_q   <= rd_pend_d;
            busy_q      <= busy_d;
            stop_q      <= stop_d;
        end
    end

    assign sda_o       = sda_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_we      = we_q;
    assign reg_re      = re_q;
    assign busy        = busy_q;
    assign stop_det    = stop_q;
    assign state_dbg_o = state_q;

endmodule
